// File: rtl/mod5_pkg.sv
// Shared constants and types for the modulo-5 sequencing counter.
package mod5_pkg;

  localparam int MOD5_MODULUS = 5;
  localparam int MOD5_CW      = 3;

  typedef logic [MOD5_CW-1:0] mod5_count_t;

  localparam mod5_count_t MOD5_MAX = 3'd4;

endpackage

// File: rtl/modn_counter_core.sv
// Generic free-running wrap counter: 0 .. MODULUS-1, then back to 0.
// Any state at or above the wrap point (only reachable through an upset)
// goes straight to 0 on the next edge instead of incrementing further.
module modn_counter_core #(
  parameter int MODULUS = 5,
  parameter int CW      = $clog2(MODULUS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] MAX_VAL = CW'(MODULUS - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;

  // Next-count decode; ">=" folds the illegal-state recovery into the wrap.
  always_comb begin
    count_nxt = count_q + CW'(1);
    if (count_q >= MAX_VAL) begin
      count_nxt = '0;
    end
  end

  // Count register, cleared immediately by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_nxt;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == MAX_VAL);

endmodule

// File: rtl/mod_5_counter.sv
// Modulo-5 up-counter used as a divide-by-5 / phase-select primitive.
// d_out is the register output directly; tc flags the last phase (4).
module mod_5_counter
  import mod5_pkg::*;
#(
  parameter int MODULUS = MOD5_MODULUS,
  parameter int CW      = MOD5_CW
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] d_out,
  output logic          tc
);

  if (MODULUS != 5) begin : g_bad_modulus
    $fatal(1, "mod_5_counter: MODULUS must be 5");
  end

  if (CW != 3) begin : g_bad_width
    $fatal(1, "mod_5_counter: CW must be 3");
  end

  modn_counter_core #(
    .MODULUS (MODULUS),
    .CW      (CW)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .count (d_out),
    .tc    (tc)
  );

  // Sanity checks on the settled count, taken mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      assert (d_out <= MOD5_MAX)
        else $error("mod_5_counter: d_out %0d out of range", d_out);
      assert (tc == (d_out == MOD5_MAX))
        else $error("mod_5_counter: tc %0b inconsistent with d_out %0d", tc, d_out);
    end
  end

endmodule

// File: tb/tb_mod_5_counter.sv
// Scoreboard bench for mod_5_counter: a modulo-5 integer model predicts the
// count after every edge; a falling-edge monitor pops and compares.
module tb_mod_5_counter;

  logic       clk;
  logic       reset;
  logic [2:0] d_out;
  logic       tc;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int model;
  bit tc_win   = 0;
  int tc_pulses = 0;

  mod_5_counter dut (
    .clk   (clk),
    .reset (reset),
    .d_out (d_out),
    .tc    (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One rising edge: advance the model and queue its prediction.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      model = (model > 4) ? 0 : (model + 1) % 5;
      exp_q.push_back(model);
    end
  endtask

  // Asynchronous reset between edges, held for a few edges, then released.
  task automatic async_reset(input int hold);
    @(negedge clk);
    #2;
    reset = 1'b0;
    model = 0;
    #1;
    check("async_rst_d_out", int'(d_out), 0);
    check("async_rst_tc", int'(tc), 0);
    repeat (hold) tick();
    @(negedge clk);
    #1;
    check("rst_hold_edge_d_out", int'(d_out), 0);
    #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    int e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("d_out", int'(d_out), e);
      check("tc", int'(tc), (e == 4) ? 1 : 0);
      if (tc_win && tc) tc_pulses++;
    end
  end

  initial begin
    bit found;
    reset = 1'b0;
    model = 0;

    // Reset held across the edge at 5 ns.
    #7;
    check("reset_hold_d_out", int'(d_out), 0);
    check("reset_hold_tc", int'(tc), 0);
    #3;
    reset = 1'b1;

    // Count sequence and terminal-count pulses over 20 cycles.
    tc_win = 1;
    repeat (20) tick();
    @(negedge clk);
    #1;
    tc_win = 0;
    check("tc_pulse_count", tc_pulses, 4);

    // Async reset while d_out == 3.
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      #1;
      if (d_out == 3'd3) found = 1;
    end
    check("found_count_3", int'(found), 1);
    #1;
    reset = 1'b0;
    model = 0;
    #1;
    check("mid_rst_d_out", int'(d_out), 0);
    check("mid_rst_tc", int'(tc), 0);
    tick();
    @(negedge clk);
    #1;
    check("mid_rst_hold_d_out", int'(d_out), 0);
    #1;
    reset = 1'b1;
    repeat (6) tick();

    // Illegal state 6 recovers to 0 on the next edge.
    @(negedge clk);
    #2;
    force dut.u_core.count_q = 3'd6;
    #1;
    release dut.u_core.count_q;
    model = 6;
    #1;
    check("upset_d_out", int'(d_out), 6);
    repeat (12) tick();

    // Long run with occasional random asynchronous resets.
    for (int i = 0; i < 1000; i++) begin
      tick();
      if ($urandom_range(0, 99) == 0) begin
        async_reset(int'($urandom_range(1, 3)));
      end
    end

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
